// File: rtl/irq_ctrl.sv
// Interrupt aggregator: rising-edge sticky pending bits, enable mask, single level irq
// with a programmable post-clear hold-off, all reached through a small sys-bus slave.
//
// state  | meaning
// IDLE   | no enabled pending source, irq low
// ACTIVE | enabled pending source present, irq high
// HOLD   | post-clear hold-off down-count, irq forced low
module irq_ctrl #(
    parameter int MNO = 2,
    parameter int MNG = 2,
    parameter int IW  = MNG + MNO + 2,
    parameter int AW  = 8,
    parameter int DW  = 32,
    parameter int CW  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] irq_src,
    input  logic [AW-1:0] bus_addr,
    input  logic [DW-1:0] bus_wdata,
    input  logic          bus_wen,
    input  logic          bus_ren,
    output logic [DW-1:0] bus_rdata,
    output logic          bus_ack,
    output logic          bus_err,
    output logic          irq
);

    localparam logic [AW-1:0] ADDR_STATUS  = AW'('h00);
    localparam logic [AW-1:0] ADDR_ENABLE  = AW'('h04);
    localparam logic [AW-1:0] ADDR_RAW     = AW'('h08);
    localparam logic [AW-1:0] ADDR_FORCE   = AW'('h0C);
    localparam logic [AW-1:0] ADDR_HOLDOFF = AW'('h10);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [IW-1:0] irq_r;
    logic [IW-1:0] pending;
    logic [IW-1:0] enable;
    logic [CW-1:0] holdoff;

    logic          sel_status, sel_enable, sel_raw, sel_force, sel_holdoff;
    logic          mapped;
    logic          rd;
    logic [IW-1:0] src_rise;
    logic [IW-1:0] w1c;
    logic [IW-1:0] frc;
    logic [DW-1:0] rdata_nxt;
    logic          act;
    logic          unused_wdata;

    assign sel_status  = (bus_addr == ADDR_STATUS);
    assign sel_enable  = (bus_addr == ADDR_ENABLE);
    assign sel_raw     = (bus_addr == ADDR_RAW);
    assign sel_force   = (bus_addr == ADDR_FORCE);
    assign sel_holdoff = (bus_addr == ADDR_HOLDOFF);
    assign mapped      = sel_status | sel_enable | sel_raw | sel_force | sel_holdoff;

    // A simultaneous wen+ren is a write; the read side is suppressed.
    assign rd = bus_ren & ~bus_wen;

    assign src_rise = irq_src & ~irq_r;
    assign w1c      = (bus_wen && sel_status) ? bus_wdata[IW-1:0] : '0;
    assign frc      = (bus_wen && sel_force)  ? bus_wdata[IW-1:0] : '0;
    assign act      = |(pending & enable);

    assign unused_wdata = ^bus_wdata[DW-1:CW];

    always_comb begin
        rdata_nxt = '0;
        if (rd) begin
            if (sel_status)  rdata_nxt[IW-1:0] = pending;
            if (sel_enable)  rdata_nxt[IW-1:0] = enable;
            if (sel_raw)     rdata_nxt[IW-1:0] = irq_src;
            if (sel_holdoff) rdata_nxt[CW-1:0] = holdoff;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_r     <= '0;
            pending   <= '0;
            enable    <= '0;
            holdoff   <= '0;
            bus_ack   <= 1'b0;
            bus_err   <= 1'b0;
            bus_rdata <= '0;
        end else begin
            irq_r   <= irq_src;
            // set terms are OR'ed last so a same-cycle set beats a clear
            pending <= (pending & ~w1c) | src_rise | frc;
            if (bus_wen && sel_enable)  enable  <= bus_wdata[IW-1:0];
            if (bus_wen && sel_holdoff) holdoff <= bus_wdata[CW-1:0];
            bus_ack   <= bus_wen | bus_ren;
            bus_err   <= (bus_wen | bus_ren) & ~mapped;
            bus_rdata <= rdata_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (act) state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (!act) begin
                    if (holdoff == '0) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = HOLD;
                        cnt_nxt   = holdoff - CW'(1);
                    end
                end
            end
            HOLD: begin
                if (cnt == '0) state_nxt = IDLE;
                else           cnt_nxt   = cnt - CW'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // irq is registered from the next state so it tracks the state register exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            irq   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            irq   <= (state_nxt == ACTIVE);
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus random traffic, all compared every cycle
// against a behavioural model of the register map and the irq low-time rule.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  irq_src;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_wen;
    logic        bus_ren;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;
    logic        irq;

    int vectors     = 0;
    int miscompares = 0;
    int low;

    logic [7:0] amap [0:5];

    irq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .irq_src   (irq_src),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wen   (bus_wen),
        .bus_ren   (bus_ren),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .bus_err   (bus_err),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Reference model: registers by address, irq as "follow act, but after
    // dropping stay low for holdoff extra cycles".
    logic [5:0]  m_pend, m_en, m_prev;
    logic [15:0] m_hold;
    logic        m_irq;
    int          m_low;
    logic        m_ack, m_err;
    logic [31:0] m_rdata;

    logic        m_mapped;
    logic [5:0]  m_clr, m_set;
    logic [31:0] m_rv;
    logic        m_act;

    always_comb begin
        m_mapped = 1'b0;
        m_clr    = '0;
        m_set    = '0;
        m_rv     = '0;
        case (bus_addr)
            8'h00: begin m_mapped = 1'b1; m_rv = 32'(m_pend); if (bus_wen) m_clr = bus_wdata[5:0]; end
            8'h04: begin m_mapped = 1'b1; m_rv = 32'(m_en); end
            8'h08: begin m_mapped = 1'b1; m_rv = 32'(irq_src); end
            8'h0C: begin m_mapped = 1'b1; if (bus_wen) m_set = bus_wdata[5:0]; end
            8'h10: begin m_mapped = 1'b1; m_rv = 32'(m_hold); end
            default: ;
        endcase
        m_act = |(m_pend & m_en);
    end

    always @(posedge clk) begin
        if (rst) begin
            m_pend  <= '0;
            m_en    <= '0;
            m_prev  <= '0;
            m_hold  <= '0;
            m_irq   <= 1'b0;
            m_low   <= 0;
            m_ack   <= 1'b0;
            m_err   <= 1'b0;
            m_rdata <= '0;
        end else begin
            m_prev  <= irq_src;
            m_pend  <= (m_pend & ~m_clr) | (irq_src & ~m_prev) | m_set;
            if (bus_wen && bus_addr == 8'h04) m_en   <= bus_wdata[5:0];
            if (bus_wen && bus_addr == 8'h10) m_hold <= bus_wdata[15:0];
            m_ack   <= bus_wen || bus_ren;
            m_err   <= (bus_wen || bus_ren) && !m_mapped;
            m_rdata <= (bus_ren && !bus_wen) ? m_rv : 32'h0;
            if (m_irq) begin
                m_irq <= m_act;
                if (!m_act) m_low <= int'(m_hold);
            end else if (m_low > 0) begin
                m_low <= m_low - 1;
            end else begin
                m_irq <= m_act;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("irq_vs_model",   32'(irq),     32'(m_irq));
        chk("ack_vs_model",   32'(bus_ack), 32'(m_ack));
        chk("err_vs_model",   32'(bus_err), 32'(m_err));
        chk("rdata_vs_model", bus_rdata,    m_rdata);
    endtask

    task automatic bus_op(input logic w, input logic r, input logic [7:0] a, input logic [31:0] d);
        bus_wen   = w;
        bus_ren   = r;
        bus_addr  = a;
        bus_wdata = d;
        tick();
        bus_wen = 1'b0;
        bus_ren = 1'b0;
    endtask

    initial begin
        amap[0] = 8'h00; amap[1] = 8'h04; amap[2] = 8'h08;
        amap[3] = 8'h0C; amap[4] = 8'h10; amap[5] = 8'h40;
        rst = 1'b1; irq_src = '0; bus_addr = '0; bus_wdata = '0; bus_wen = 1'b0; bus_ren = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1: reset values, ack one cycle after ren
        chk("t1_irq", 32'(irq), 32'd0);
        bus_op(1'b0, 1'b1, 8'h00, 32'h0);
        chk("t1_ack", 32'(bus_ack), 32'd1);
        chk("t1_err", 32'(bus_err), 32'd0);
        chk("t1_status", bus_rdata, 32'h0);
        bus_op(1'b0, 1'b1, 8'h04, 32'h0);
        chk("t1_enable", bus_rdata, 32'h0);
        bus_op(1'b0, 1'b1, 8'h10, 32'h0);
        chk("t1_holdoff", bus_rdata, 32'h0);
        tick();
        chk("t1_ack_gone", 32'(bus_ack), 32'd0);
        chk("t1_irq_low", 32'(irq), 32'd0);

        // 2: one-cycle pulse on osc[0], then W1C
        bus_op(1'b1, 1'b0, 8'h04, 32'h3F);
        irq_src = 6'h04;
        tick();
        chk("t2_irq_n1", 32'(irq), 32'd0);
        irq_src = 6'h00;
        bus_op(1'b0, 1'b1, 8'h00, 32'h0);
        chk("t2_status", bus_rdata, 32'h04);
        chk("t2_irq_n2", 32'(irq), 32'd1);
        bus_op(1'b1, 1'b0, 8'h00, 32'h04);
        chk("t2_irq_ack", 32'(irq), 32'd1);
        tick();
        chk("t2_irq_clr", 32'(irq), 32'd0);

        // 3: FORCE with enable off, then enable it
        bus_op(1'b1, 1'b0, 8'h04, 32'h0);
        bus_op(1'b1, 1'b0, 8'h0C, 32'h20);
        bus_op(1'b0, 1'b1, 8'h00, 32'h0);
        chk("t3_status", bus_rdata, 32'h20);
        chk("t3_irq_masked", 32'(irq), 32'd0);
        bus_op(1'b0, 1'b1, 8'h0C, 32'h0);
        chk("t3_force_rd", bus_rdata, 32'h0);
        bus_op(1'b1, 1'b0, 8'h04, 32'h20);
        chk("t3_irq_p1", 32'(irq), 32'd0);
        tick();
        chk("t3_irq_p2", 32'(irq), 32'd1);

        // 4: hold-off of 5 with a new edge one cycle after the clear
        bus_op(1'b1, 1'b0, 8'h10, 32'h5);
        bus_op(1'b1, 1'b0, 8'h00, 32'h20);
        chk("t4_irq_q1", 32'(irq), 32'd1);
        irq_src  = 6'h20;
        bus_ren  = 1'b1;
        bus_addr = 8'h00;
        low = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i > 0) chk("t4_pend", bus_rdata, 32'h20);
            if (irq) break;
            low++;
        end
        bus_ren = 1'b0;
        chk("t4_low_cycles", 32'(low), 32'd6);
        chk("t4_irq_back", 32'(irq), 32'd1);

        // 5: set wins over clear, unmapped read, wen+ren together
        bus_op(1'b1, 1'b0, 8'h00, 32'h20);
        irq_src = 6'h21;
        bus_op(1'b1, 1'b0, 8'h00, 32'h01);
        bus_op(1'b0, 1'b1, 8'h00, 32'h0);
        chk("t5_set_wins", bus_rdata, 32'h01);
        bus_op(1'b0, 1'b1, 8'h40, 32'h0);
        chk("t5_unmapped_ack", 32'(bus_ack), 32'd1);
        chk("t5_unmapped_err", 32'(bus_err), 32'd1);
        chk("t5_unmapped_rdata", bus_rdata, 32'h0);
        bus_op(1'b1, 1'b1, 8'h04, 32'h15);
        chk("t5_wr_rd_rdata", bus_rdata, 32'h0);
        chk("t5_wr_rd_err", 32'(bus_err), 32'd0);
        bus_op(1'b0, 1'b1, 8'h04, 32'h0);
        chk("t5_wr_rd_applied", bus_rdata, 32'h15);

        // 6: reset in the middle of a hold-off count
        for (int i = 0; i < 40; i++) begin
            if (irq) break;
            tick();
        end
        chk("t6_irq_active", 32'(irq), 32'd1);
        bus_op(1'b1, 1'b0, 8'h00, 32'h01);
        tick();
        tick();
        rst = 1'b1;
        irq_src = 6'h00;
        tick();
        chk("t6_irq_rst", 32'(irq), 32'd0);
        chk("t6_ack_rst", 32'(bus_ack), 32'd0);
        rst = 1'b0;
        bus_op(1'b0, 1'b1, 8'h00, 32'h0);
        chk("t6_status", bus_rdata, 32'h0);
        bus_op(1'b0, 1'b1, 8'h04, 32'h0);
        chk("t6_enable", bus_rdata, 32'h0);
        bus_op(1'b0, 1'b1, 8'h10, 32'h0);
        chk("t6_holdoff", bus_rdata, 32'h0);
        bus_op(1'b1, 1'b0, 8'h04, 32'h01);
        bus_op(1'b1, 1'b0, 8'h0C, 32'h01);
        chk("t6_idle_s1", 32'(irq), 32'd0);
        tick();
        chk("t6_idle_s2", 32'(irq), 32'd1);

        // 7: source already high when reset releases
        rst = 1'b1;
        irq_src = 6'h02;
        tick();
        tick();
        rst = 1'b0;
        tick();
        bus_op(1'b0, 1'b1, 8'h00, 32'h0);
        chk("t7_high_at_reset", bus_rdata, 32'h02);

        // random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) irq_src = irq_src ^ (6'd1 << $urandom_range(0, 5));
            bus_addr  = amap[$urandom_range(0, 5)];
            bus_wdata = $urandom;
            if (bus_addr == 8'h10) bus_wdata = bus_wdata & 32'hFFFF_0007;
            case ($urandom_range(0, 5))
                0:       begin bus_wen = 1'b1; bus_ren = 1'b0; end
                1:       begin bus_wen = 1'b0; bus_ren = 1'b1; end
                2:       begin bus_wen = 1'b1; bus_ren = 1'b1; end
                default: begin bus_wen = 1'b0; bus_ren = 1'b0; end
            endcase
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        bus_wen = 1'b0;
        bus_ren = 1'b0;
        rst     = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
